// File: rtl/display_scanner_pkg.sv
// Shared types and constants for the multiplexed BCD display scanner.
package display_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    LAMP = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9;

  // A load word is displayable only if every nibble is a decimal digit.
  function automatic logic bcd_valid(input logic [4*NUM_DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[4*k +: 4] > 4'(BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/display_scanner_tick.sv
// Digit-slot prescaler: one-cycle tick every DIV clocks, restartable via clr.
module scan_tick #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A clear in the same cycle swallows the tick so the restarted slot is full length.
  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/display_scanner.sv
// Four-digit BCD display scanner with frame-synchronous value update,
// leading-zero blanking and a frame-counted lamp test.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int LT_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  output logic        ready,
  output logic        err,
  input  logic        blank_en,
  input  logic        lamp_req,
  output logic [3:0]  data,
  output logic        LT,
  output logic        RBI,
  output logic        BI,
  output logic [3:0]  digit_sel
);

  localparam int FW = (LT_FRAMES > 1) ? $clog2(LT_FRAMES) : 1;
  localparam logic [FW-1:0] LT_LAST = FW'(LT_FRAMES - 1);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] pend, pend_nxt;
  logic [15:0] active, active_nxt;
  logic        pend_full, pend_full_nxt;
  logic        ever, ever_nxt;
  logic [FW-1:0] lt_cnt, lt_cnt_nxt;
  logic        err_nxt;

  logic        tick, clr, acc, good, frame_end;

  // The prescaler idles cleared so every scan or lamp test starts on a full slot.
  assign clr = (state == IDLE) || lamp_req;

  scan_tick #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  assign acc       = load && !pend_full;
  assign good      = acc && bcd_valid(value);
  assign frame_end = tick && (idx == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd3;
      pend      <= '0;
      active    <= '0;
      pend_full <= 1'b0;
      ever      <= 1'b0;
      lt_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      pend      <= pend_nxt;
      active    <= active_nxt;
      pend_full <= pend_full_nxt;
      ever      <= ever_nxt;
      lt_cnt    <= lt_cnt_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    pend_nxt      = pend;
    active_nxt    = active;
    pend_full_nxt = pend_full;
    ever_nxt      = ever;
    lt_cnt_nxt    = lt_cnt;
    err_nxt       = acc && !good;

    case (state)
      IDLE: begin
        if (good) begin
          active_nxt = value;
          ever_nxt   = 1'b1;
          state_nxt  = SCAN;
          idx_nxt    = 2'd3;
        end
      end
      SCAN, LAMP: begin
        if (tick) idx_nxt = idx - 2'd1;
        // Transfer before capture: a load on the frame-end cycle waits a whole frame.
        if (frame_end && pend_full) begin
          active_nxt    = pend;
          pend_full_nxt = 1'b0;
        end
        if (good) begin
          pend_nxt      = value;
          pend_full_nxt = 1'b1;
          ever_nxt      = 1'b1;
        end
        if ((state == LAMP) && frame_end) begin
          if (lt_cnt == LT_LAST) begin
            lt_cnt_nxt = '0;
            state_nxt  = ever_nxt ? SCAN : IDLE;
          end else begin
            lt_cnt_nxt = lt_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (lamp_req) begin
      state_nxt  = LAMP;
      lt_cnt_nxt = '0;
      idx_nxt    = 2'd3;
    end
  end

  // Digit select and data both decode the single idx register.
  assign digit_sel = 4'b0001 << idx;
  assign data      = active[{idx, 2'b00} +: 4];
  assign BI        = (state == IDLE);
  assign LT        = (state == LAMP);
  assign ready     = !pend_full;

  logic z3, z2, z1;
  assign z3 = (active[15:12] == 4'd0);
  assign z2 = z3 && (active[11:8] == 4'd0);
  assign z1 = z2 && (active[7:4] == 4'd0);

  always_comb begin
    RBI = 1'b0;
    if ((state != IDLE) && blank_en) begin
      case (idx)
        2'd3:    RBI = z3;
        2'd2:    RBI = z2;
        2'd1:    RBI = z1;
        default: RBI = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Randomized scoreboard bench for display_scanner against a cycle-level reference model.
module tb_display_scanner;
  localparam int DIV   = 4;
  localparam int LTF   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b1;
  logic        rst_n = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0, blank_en = 1'b0, lamp_req = 1'b0;
  logic        ready, err, LT, RBI, BI;
  logic [3:0]  data, digit_sel;

  display_scanner #(.SCAN_DIV(DIV), .LT_FRAMES(LTF)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .ready(ready), .err(err),
    .blank_en(blank_en), .lamp_req(lamp_req), .data(data), .LT(LT), .RBI(RBI),
    .BI(BI), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] data;
    logic bi, rbi, lt, ready, err;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  // Reference model: mode 0=idle 1=scan 2=lamp; phase = clocks into the current frame.
  int          m_mode, m_phase, m_left;
  logic [15:0] m_shown, m_pend;
  logic        m_pv, m_ever, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic bcd_ok(input logic [15:0] v);
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_phase = 0; m_left = 0; m_shown = '0; m_pend = '0;
    m_pv = 1'b0; m_ever = 1'b0; m_err = 1'b0;
  endtask

  task automatic m_step(input logic ld, input logic [15:0] v, input logic lr);
    logic acc, good, fe;
    if (!rst_n) begin m_reset(); return; end
    acc  = ld && !m_pv;
    good = acc && bcd_ok(v);
    fe   = (m_mode != 0) && !lr && (((m_phase + 1) % FRAME) == 0);
    m_err = acc && !good;
    if (m_mode == 0) begin
      if (good) begin m_shown = v; m_ever = 1'b1; m_mode = 1; m_phase = 0; end
    end else begin
      if (fe && m_pv) begin m_shown = m_pend; m_pv = 1'b0; end
      if (good) begin m_pend = v; m_pv = 1'b1; m_ever = 1'b1; end
      m_phase = (m_phase + 1) % FRAME;
      if (m_mode == 2 && fe) begin
        m_left--;
        if (m_left == 0) m_mode = m_ever ? 1 : 0;
      end
    end
    if (lr) begin m_mode = 2; m_left = LTF; m_phase = 0; end
  endtask

  function automatic exp_t m_out(input logic be);
    exp_t e;
    int d;
    d = (m_mode == 0) ? 3 : 3 - ((m_phase / DIV) % 4);
    e.sel   = 4'(1 << d);
    e.data  = m_shown[4*d +: 4];
    e.bi    = (m_mode == 0);
    e.lt    = (m_mode == 2);
    e.ready = !m_pv;
    e.err   = m_err;
    e.rbi   = 1'b0;
    if (m_mode != 0 && be && d > 0) begin
      e.rbi = 1'b1;
      for (int k = d; k < 4; k++) if (m_shown[4*k +: 4] != 4'd0) e.rbi = 1'b0;
    end
    return e;
  endfunction

  // One clock: drive inputs, queue the expected outputs for this cycle, advance the model.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic lr, input logic be);
    load = ld; value = v; lamp_req = lr; blank_en = be;
    q.push_back(m_out(be));
    @(posedge clk);
    m_step(ld, v, lr);
    #1;
  endtask

  task automatic idle_n(input int n, input logic be);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, be);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("digit_sel", 32'(digit_sel), 32'(e.sel));
        chk("data", 32'(data), 32'(e.data));
        chk("BI", 32'(BI), 32'(e.bi));
        chk("RBI", 32'(RBI), 32'(e.rbi));
        chk("LT", 32'(LT), 32'(e.lt));
        chk("ready", 32'(ready), 32'(e.ready));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic [15:0] v;
    m_reset();
    #1 rst_n = 1'b0;
    idle_n(3, 1'b1);
    rst_n = 1'b1;
    // Lamp test before any load returns to IDLE.
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    idle_n(40, 1'b0);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    idle_n(20, 1'b0);
    cyc(1'b1, 16'h12A4, 1'b0, 1'b0);
    idle_n(4, 1'b0);
    cyc(1'b1, 16'h0050, 1'b0, 1'b1);
    idle_n(40, 1'b1);
    cyc(1'b1, 16'h1111, 1'b0, 1'b0);
    idle_n(38, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    idle_n(40, 1'b0);
    // Lamp test from SCAN: LT must stay high for exactly two frames.
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    n = 0;
    while (LT === 1'b1 && n < 100) begin n++; cyc(1'b0, 16'h0, 1'b0, 1'b0); end
    chk("lt_duration", 32'(n), 32'(2 * FRAME));
    idle_n(10, 1'b0);
    // Restart in LAMP, then asynchronous reset mid-lamp.
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    idle_n(10, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    idle_n(5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_BI", 32'(BI), 32'd1);
    chk("async_LT", 32'(LT), 32'd0);
    chk("async_ready", 32'(ready), 32'd1);
    chk("async_sel", 32'(digit_sel), 32'h8);
    chk("async_data", 32'(data), 32'd0);
    m_reset();
    idle_n(2, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 16'h0987, 1'b0, 1'b1);
    idle_n(20, 1'b1);
    // Load and lamp request in the same cycle.
    cyc(1'b1, 16'h4321, 1'b1, 1'b0);
    idle_n(40, 1'b0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) v = 16'($urandom());
      else for (int k = 0; k < 4; k++)
        v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      cyc(($urandom_range(0, 7) == 0), v, ($urandom_range(0, 99) == 0),
          1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot (minimum 2).
REQ-002 SHALL have parameter LT_FRAMES, default 64, number of full scan frames that lamp test lasts (minimum 1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 value  input  16  four BCD digits; [15:12] most significant, [3:0] least significant.
REQ-006 load  input  1  request to display value; accepted when load && ready.
REQ-007 ready  output  1  high when a new value can be accepted.
REQ-008 err  output  1  one-cycle pulse when a load is rejected.
REQ-009 blank_en  input  1  1 = suppress leading zeros.
REQ-010 lamp_req  input  1  single-cycle pulse that starts lamp test.
REQ-011 data  output  4  BCD digit presented to the downstream 7-segment decoder.
REQ-012 LT  output  1  1 = decoder lights all segments.
REQ-013 RBI  output  1  1 = decoder blanks a zero digit.
REQ-014 BI  output  1  1 = decoder blanks the digit.
REQ-015 digit_sel  output  4  one-hot, active-high digit enable; bit i drives digit i.

Function
REQ-016 SHALL implement states IDLE, SCAN and LAMP.
- IDLE: BI=1, LT=0.
- SCAN: normal display.
- LAMP: LT=1, BI=0.
REQ-017 SHALL generate a slot tick every SCAN_DIV clocks; digit index i rotates 3,2,1,0,3,... on each tick.
- digit_sel = one-hot(i) in every state.
- A frame ends on the tick that leaves i=0.
REQ-018 data SHALL equal the active-shadow nibble for digit i, from the same register as digit_sel (no skew between them).
REQ-019 SHALL reject a load with any nibble >9:
- err=1 for one cycle;
- pending and active registers unchanged.
REQ-020 A valid accepted load SHALL:
- be captured into a pending register;
- drop ready to 0 on the next cycle.
REQ-021 Pending SHALL move to the active shadow only at a frame end; ready returns to 1 on the cycle after the transfer. A single frame never mixes old and new digits.
REQ-022 In IDLE, a valid accepted load SHALL transfer to active immediately and enter SCAN at i=3 with the prescaler cleared.
REQ-023 While ready=0, load SHALL be ignored, with no err pulse.
REQ-024 RBI for digit i SHALL be 1 only when all of the following hold:
- blank_en=1;
- i>0;
- active digits i..3 are all zero.
Digit 0 always has RBI=0.
REQ-025 lamp_req in IDLE or SCAN SHALL:
- enter LAMP on the next cycle;
- keep LT=1 for exactly LT_FRAMES frames;
- then return to SCAN if a value was ever loaded, otherwise to IDLE.
REQ-026 lamp_req in LAMP SHALL restart the LT_FRAMES count.
REQ-027 Loads SHALL be accepted in LAMP; the pending-to-active transfer still occurs at frame ends.
REQ-028 When load and lamp_req occur in the same cycle, both SHALL take effect: the load is accepted and LAMP is entered.
REQ-029 Frame counter and prescaler SHALL wrap without overflow; widths are sized by clog2 of the parameters.

Reset
REQ-030 While rst_n=0, outputs SHALL be:
- state IDLE, i=3, digit_sel=4'b1000;
- data=0, BI=1, RBI=0, LT=0;
- ready=1, err=0.
All counters, pending and active registers SHALL be 0.
REQ-031 Reset asserted mid-frame or mid-lamp-test SHALL abort immediately to the REQ-030 values; the first load after release is accepted.

Structure
REQ-032 The shared package SHALL hold:
- state enum {IDLE, SCAN, LAMP};
- constant NUM_DIGITS=4;
- constant BCD_MAX=9.
REQ-033 The prescaler SHALL be the sub-module scan_tick (parameter DIV, output single-cycle tick); the rest SHALL be flat in display_scanner.

Verification
REQ-034 The bench SHALL run with SCAN_DIV=4 and LT_FRAMES=2, and SHALL cover these scenarios:
- Reset, then load 16'h1234 → digit_sel 1000,0100,0010,0001 with data 1,2,3,4, each held 4 clocks; BI=0, RBI=0 throughout.
- blank_en=1, value 16'h0050 → RBI=1 on digits 3 and 2; RBI=0 on digits 1 and 0 (data 5, 0).
- load 16'h12A4 → err pulses 1 cycle; display unchanged; ready stays 1.
- While showing 16'h1111, load 16'h2222 mid-frame → ready=0 until the frame end; the next frame is all 2s; no mixed frame.
- lamp_req during SCAN → LT=1 for exactly 32 clocks (2 frames), then LT=0 with the prior value shown.
- rst_n pulsed low during LAMP → BI=1, LT=0, ready=1 asynchronously; IDLE after release.
